// File: rtl/video_shift_ctrl.sv
// video_shift_ctrl: write/read controller for a bank of COL line RAMs forming a vertical tap window.
// Incoming pixels go to line RAM wr_point at column wr_addr. The read side uses the same column,
// and rd_mask reports how many RAMs already hold a full line of the current frame.
// Optional feature: define VIDEO_SHIFT_CTRL_LEN_CHECK_EN to build the per-frame line-length
// consistency check that drives len_err. Without it, len_err is tied low.
module video_shift_ctrl #(
    parameter int unsigned COL   = 2,
    parameter int unsigned DSIZE = 10,
    parameter int unsigned ASIZE = 10
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_vs,
    input  logic             in_de,
    input  logic [DSIZE-1:0] in_data,
    output logic             wr_en,
    output logic [ASIZE-1:0] wr_addr,
    output logic [DSIZE-1:0] wr_data,
    output logic             rd_en,
    output logic [ASIZE-1:0] rd_addr,
    output logic [3:0]       wr_point,
    output logic [3:0]       rd_point,
    output logic [COL-1:0]   rd_mask,
    output logic             out_vs,
    output logic             out_de,
    output logic             ovf,
    output logic             len_err
);

    // Controller states. WAIT_VS is reserved and behaves like IDLE.
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHblank = 2'd1;
    localparam logic [1:0] StLine   = 2'd2;
    localparam logic [1:0] StWaitVs = 2'd3;

    localparam logic [3:0]       LastPoint = 4'(COL - 1);
    localparam logic [4:0]       ColCnt    = 5'(COL);
    localparam logic [ASIZE-1:0] AddrMax   = '1;

    logic [1:0]       state_q, state_d;
    logic [ASIZE-1:0] col_q, col_d;           // next column to write on this line
    logic             sat_q, sat_d;           // last column written; drop the rest of the line
    logic             wr_en_q, wr_en_d;
    logic [ASIZE-1:0] wr_addr_q, wr_addr_d;
    logic [DSIZE-1:0] wr_data_q, wr_data_d;
    logic [3:0]       wr_point_q, wr_point_d;
    logic [4:0]       lines_done_q, lines_done_d;
    logic [COL-1:0]   mask_q, mask_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       vs_pipe_q;
    logic [2:0]       de_pipe_q;
    logic             accept;

    // A pixel is taken whenever a frame is open, including the restart cycle itself.
    assign accept = in_de && (in_vs || (state_q == StHblank) || (state_q == StLine));

    // Next-state: frame restart, line end bookkeeping, then pixel write/drop.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        sat_d        = sat_q;
        wr_point_d   = wr_point_q;
        lines_done_d = lines_done_q;
        ovf_d        = ovf_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = wr_data_q;

        if (in_vs) begin
            // Restart wins over everything; an open line is abandoned without advancing.
            state_d      = StHblank;
            col_d        = '0;
            sat_d        = 1'b0;
            wr_point_d   = '0;
            lines_done_d = '0;
            ovf_d        = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StWaitVs: ;
                StHblank: begin
                    if (in_de) begin
                        state_d = StLine;
                    end
                end
                StLine: begin
                    if (!in_de) begin
                        // First blank cycle: advance while wr_en is already low.
                        state_d    = StHblank;
                        col_d      = '0;
                        sat_d      = 1'b0;
                        wr_point_d = (wr_point_q == LastPoint) ? 4'd0 : wr_point_q + 4'd1;
                        if (lines_done_q != ColCnt) begin
                            lines_done_d = lines_done_q + 5'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (accept) begin
            state_d = StLine;
            if (sat_d) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = col_d;
                wr_data_d = in_data;
                if (col_d == AddrMax) begin
                    sat_d = 1'b1;
                end
                col_d = col_d + ASIZE'(1);
            end
        end
    end

    // Valid-tap mask follows the line count that will be registered this edge.
    always_comb begin
        mask_d = '0;
        for (int k = 0; k < int'(COL); k++) begin
            mask_d[k] = (5'(k) < lines_done_d);
        end
    end

    // Controller and RAM-side output registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            sat_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_point_q   <= '0;
            lines_done_q <= '0;
            mask_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            sat_q        <= sat_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_point_q   <= wr_point_d;
            lines_done_q <= lines_done_d;
            mask_q       <= mask_d;
            ovf_q        <= ovf_d;
        end
    end

    // Sync delay: controller stage, RAM read stage, output ordering stage.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vs_pipe_q <= '0;
            de_pipe_q <= '0;
        end else begin
            vs_pipe_q <= {vs_pipe_q[1:0], in_vs};
            de_pipe_q <= {de_pipe_q[1:0], in_de};
        end
    end

`ifdef VIDEO_SHIFT_CTRL_LEN_CHECK_EN
    // Two spare bits so a line longer than the RAM still counts distinctly.
    localparam int unsigned LenW = ASIZE + 2;

    logic [LenW-1:0] len_cnt_q, len_cnt_d;
    logic [LenW-1:0] len_ref_q, len_ref_d;
    logic            ref_valid_q, ref_valid_d;
    logic            len_err_q, len_err_d;
    logic            line_end;

    assign line_end = !in_vs && (state_q == StLine) && !in_de;

    // First line of a frame sets the reference; later lines are compared against it.
    always_comb begin
        len_cnt_d   = len_cnt_q;
        len_ref_d   = len_ref_q;
        ref_valid_d = ref_valid_q;
        len_err_d   = len_err_q;
        if (in_vs) begin
            len_cnt_d   = '0;
            ref_valid_d = 1'b0;
            len_err_d   = 1'b0;
        end else if (line_end) begin
            if (!ref_valid_q) begin
                len_ref_d   = len_cnt_q;
                ref_valid_d = 1'b1;
            end else if (len_cnt_q != len_ref_q) begin
                len_err_d = 1'b1;
            end
            len_cnt_d = '0;
        end
        if (accept && (len_cnt_d != '1)) begin
            len_cnt_d = len_cnt_d + LenW'(1);
        end
    end

    // Length-check registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            len_cnt_q   <= '0;
            len_ref_q   <= '0;
            ref_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            len_cnt_q   <= len_cnt_d;
            len_ref_q   <= len_ref_d;
            ref_valid_q <= ref_valid_d;
            len_err_q   <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    // Read side shares the write column; read ordering reference tracks the write pointer.
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_en    = wr_en_q;
    assign rd_addr  = wr_addr_q;
    assign wr_point = wr_point_q;
    assign rd_point = wr_point_q;
    assign rd_mask  = mask_q;
    assign out_vs   = vs_pipe_q[2];
    assign out_de   = de_pipe_q[2];
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_video_shift_ctrl.sv
// Bench for video_shift_ctrl: two instances (COL=3/ASIZE=3 and COL=2/ASIZE=5) share one
// stimulus stream. A frame/line-level model predicts every output each cycle; directed
// sequences add literal expectations.
module tb_video_shift_ctrl;

    localparam int DW   = 8;
    localparam int COL0 = 3;
    localparam int AS0  = 3;
    localparam int COL1 = 2;
    localparam int AS1  = 5;

`ifdef VIDEO_SHIFT_CTRL_LEN_CHECK_EN
    localparam logic LEN_EN = 1'b1;
`else
    localparam logic LEN_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rst   = 1'b1;
    logic          in_vs = 1'b0;
    logic          in_de = 1'b0;
    logic [DW-1:0] in_data = '0;

    always #5 clock = ~clock;

    logic            we0, re0, ov0, le0, ovs0, ode0;
    logic [AS0-1:0]  wa0, ra0;
    logic [DW-1:0]   wd0;
    logic [3:0]      wp0, rp0;
    logic [COL0-1:0] m0;

    logic            we1, re1, ov1, le1, ovs1, ode1;
    logic [AS1-1:0]  wa1, ra1;
    logic [DW-1:0]   wd1;
    logic [3:0]      wp1, rp1;
    logic [COL1-1:0] m1;

    video_shift_ctrl #(.COL(COL0), .DSIZE(DW), .ASIZE(AS0)) dut0 (
        .clock(clock), .rst(rst), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
        .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .rd_en(re0), .rd_addr(ra0),
        .wr_point(wp0), .rd_point(rp0), .rd_mask(m0), .out_vs(ovs0), .out_de(ode0),
        .ovf(ov0), .len_err(le0)
    );

    video_shift_ctrl #(.COL(COL1), .DSIZE(DW), .ASIZE(AS1)) dut1 (
        .clock(clock), .rst(rst), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
        .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .rd_en(re1), .rd_addr(ra1),
        .wr_point(wp1), .rd_point(rp1), .rd_mask(m1), .out_vs(ovs1), .out_de(ode1),
        .ovf(ov1), .len_err(le1)
    );

    int checks   = 0;
    int failures = 0;
    int w0_writes = 0;

    // Model state per instance.
    int cols [2] = '{COL0, COL1};
    int asz  [2] = '{AS0, AS1};
    int started [2];
    int in_line [2];
    int cnt     [2];
    int mwp     [2];
    int mld     [2];
    int movf    [2];
    int mlerr   [2];
    int refv    [2];
    int reflen  [2];
    int e_we    [2];
    int e_wa    [2];
    int e_wd    [2];
    logic [2:0] dvs = '0;
    logic [2:0] dde = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            started[i] = 0; in_line[i] = 0; cnt[i] = 0; mwp[i] = 0; mld[i] = 0;
            movf[i] = 0; mlerr[i] = 0; refv[i] = 0; reflen[i] = 0;
            e_we[i] = 0; e_wa[i] = 0; e_wd[i] = 0;
        end
        dvs = '0;
        dde = '0;
    endtask

    task automatic model_step(input int i, input logic vs, input logic de, input int d);
        if (vs) begin
            started[i] = 1; in_line[i] = 0; cnt[i] = 0; mwp[i] = 0; mld[i] = 0;
            movf[i] = 0; mlerr[i] = 0; refv[i] = 0;
        end else if (in_line[i] != 0 && !de) begin
            in_line[i] = 0;
            mwp[i] = (mwp[i] + 1) % cols[i];
            if (mld[i] < cols[i]) mld[i]++;
            if (refv[i] == 0) begin
                reflen[i] = cnt[i];
                refv[i] = 1;
            end else if (cnt[i] != reflen[i]) begin
                mlerr[i] = 1;
            end
        end
        e_we[i] = 0;
        e_wa[i] = 0;
        if (de && started[i] != 0) begin
            if (in_line[i] == 0) begin
                in_line[i] = 1;
                cnt[i] = 0;
            end
            if (cnt[i] < (1 << asz[i])) begin
                e_we[i] = 1;
                e_wa[i] = cnt[i];
                e_wd[i] = d;
            end else begin
                movf[i] = 1;
            end
            cnt[i]++;
        end
    endtask

    always @(posedge clock) begin
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) model_step(i, in_vs, in_de, int'(in_data));
            dvs = {dvs[1:0], in_vs};
            dde = {dde[1:0], in_de};
        end
    end

    task automatic cmp_inst(input int i, input logic we, input logic re, input int wa,
                            input int ra, input int wd, input int wpt, input int rpt,
                            input int mask, input logic ov, input logic le,
                            input logic ovs, input logic ode);
        cmp($sformatf("wr_en%0d", i), 32'(we), 32'(e_we[i]));
        cmp($sformatf("rd_en%0d", i), 32'(re), 32'(e_we[i]));
        cmp($sformatf("wr_addr%0d", i), wa, e_wa[i]);
        cmp($sformatf("rd_addr%0d", i), ra, e_wa[i]);
        if (e_we[i] != 0) cmp($sformatf("wr_data%0d", i), wd, e_wd[i]);
        cmp($sformatf("wr_point%0d", i), wpt, mwp[i]);
        cmp($sformatf("rd_point%0d", i), rpt, mwp[i]);
        cmp($sformatf("rd_mask%0d", i), mask, (1 << mld[i]) - 1);
        cmp($sformatf("ovf%0d", i), 32'(ov), movf[i]);
        cmp($sformatf("len_err%0d", i), 32'(le), LEN_EN ? mlerr[i] : 0);
        cmp($sformatf("out_vs%0d", i), 32'(ovs), 32'(dvs[2]));
        cmp($sformatf("out_de%0d", i), 32'(ode), 32'(dde[2]));
    endtask

    // Compare process, mid-cycle.
    always @(negedge clock) begin
        if (rst) begin
            cmp("rst_outs0", {we0, wa0, wd0, re0, ra0, wp0, rp0, m0, ovs0, ode0, ov0, le0}, 0);
            cmp("rst_outs1a", {we1, wa1, wd1, re1, ra1}, 0);
            cmp("rst_outs1b", {wp1, rp1, m1, ovs1, ode1, ov1, le1}, 0);
        end else begin
            if (we0) w0_writes++;
            cmp_inst(0, we0, re0, int'(wa0), int'(ra0), int'(wd0), int'(wp0), int'(rp0),
                     int'(m0), ov0, le0, ovs0, ode0);
            cmp_inst(1, we1, re1, int'(wa1), int'(ra1), int'(wd1), int'(wp1), int'(rp1),
                     int'(m1), ov1, le1, ovs1, ode1);
        end
    end

    task automatic drive(input logic vs, input logic de);
        in_vs   = vs;
        in_de   = de;
        in_data = DW'($urandom);
        @(posedge clock);
        #1;
    endtask

    task automatic line(input int n, input int blank);
        for (int p = 0; p < n; p++) drive(1'b0, 1'b1);
        for (int b = 0; b < blank; b++) drive(1'b0, 1'b0);
    endtask

    int wp_seq   [4] = '{0, 1, 2, 0};
    int mask_seq [4] = '{0, 1, 3, 7};
    int snap;
    logic [9:0] pat;
    int len;
    int bl;

    initial begin
        repeat (3) drive(1'b0, 1'b0);
        rst = 1'b0;

        // Reset mid-line, then in_de without in_vs must not write.
        drive(1'b1, 1'b0);
        for (int p = 0; p < 4; p++) drive(1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b1);
        cmp("rst_midline_we", 32'(we0), 0);
        cmp("rst_midline_addr", 32'(wa0), 0);
        rst = 1'b0;
        for (int p = 0; p < 5; p++) drive(1'b0, 1'b1);
        cmp("idle_no_write", 32'(we0), 0);
        drive(1'b0, 1'b0);

        // COL=3: four 8-pixel lines with 4-cycle blanks.
        drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        cmp("c3_start_mask", 32'(m0), 0);
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin
                drive(1'b0, 1'b1);
                if (p == 0) begin
                    cmp("c3_wp", 32'(wp0), wp_seq[l]);
                    cmp("c3_mask", 32'(m0), mask_seq[l]);
                    cmp("c3_addr_first", 32'(wa0), 0);
                end
                if (p == 7) cmp("c3_addr_last", 32'(wa0), 7);
            end
            repeat (4) drive(1'b0, 1'b0);
        end
        cmp("c3_mask_end", 32'(m0), 7);

        // ASIZE=3: 10-pixel line keeps 8 writes and sets ovf until the next in_vs.
        drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        snap = w0_writes;
        for (int p = 0; p < 10; p++) begin
            drive(1'b0, 1'b1);
            if (p == 8) cmp("ovf_drop9", 32'(we0), 0);
        end
        repeat (3) drive(1'b0, 1'b0);
        cmp("ovf_writes", w0_writes - snap, 8);
        cmp("ovf_set", 32'(ov0), 1);
        line(5, 3);
        cmp("ovf_sticky", 32'(ov0), 1);
        drive(1'b1, 1'b0);
        cmp("ovf_clear_vs", 32'(ov0), 0);

        // in_vs together with pixel 5 of line 2.
        repeat (2) drive(1'b0, 1'b0);
        line(8, 4);
        for (int p = 0; p < 4; p++) drive(1'b0, 1'b1);
        cmp("vsmid_pre_wp", 32'(wp0), 1);
        drive(1'b1, 1'b1);
        cmp("vsmid_wp", 32'(wp0), 0);
        cmp("vsmid_mask", 32'(m0), 0);
        cmp("vsmid_we", 32'(we0), 1);
        cmp("vsmid_addr", 32'(wa0), 0);
        line(3, 4);
        drive(1'b0, 1'b1);
        cmp("vsmid_next_addr", 32'(wa0), 0);
        line(5, 5);

        // out_de alignment: 6-cycle in_de burst.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, k < 6);
            pat[k] = ode0;
        end
        cmp("outde_align", 32'(pat), 32'h0FC);

        // Line length check: 16, 16, 15.
        drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        line(16, 3);
        line(16, 3);
        cmp("len_ok_after2", 32'(le1), 0);
        line(15, 3);
        cmp("len_err_after3", 32'(le1), 32'(LEN_EN));
        cmp("len_err_after3_i0", 32'(le0), 32'(LEN_EN));

        // Randomized lines, blanks down to 1 cycle, stray restarts, one reset.
        drive(1'b1, 1'b0);
        for (int n = 0; n < 80; n++) begin
            len = $urandom_range(1, 14);
            bl  = $urandom_range(1, 5);
            if ($urandom_range(0, 15) == 0) drive(1'b1, 1'($urandom_range(0, 1)));
            for (int p = 0; p < len; p++) drive($urandom_range(0, 40) == 0, 1'b1);
            for (int b = 0; b < bl; b++) drive(1'b0, 1'b0);
            if (n == 40) begin
                drive(1'b0, 1'b1);
                rst = 1'b1;
                drive(1'b0, 1'b1);
                rst = 1'b0;
                drive(1'b1, 1'b0);
            end
        end
        repeat (5) drive(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_shift_ctrl.md
VIDEO_SHIFT_CTRL -- requirements
Module: video_shift_ctrl

Interface
REQ-001 Parameter COL, default 2: number of line RAMs driven downstream; legal range 1..16.
REQ-002 Parameter DSIZE, default 10: pixel width in bits.
REQ-003 Parameter ASIZE, default 10: column address width; maximum line length is 2^ASIZE pixels.
REQ-004 Ports SHALL be the following, with one clock and an asynchronous active-high reset:
- clock  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- in_vs  in  1  frame-start pulse, one cycle
- in_de  in  1  pixel valid
- in_data  in  DSIZE  pixel
- wr_en  out  1  line-RAM write enable
- wr_addr  out  ASIZE  write column
- wr_data  out  DSIZE  write pixel
- rd_en  out  1  line-RAM read enable
- rd_addr  out  ASIZE  read column
- wr_point  out  4  RAM index being written
- rd_point  out  4  RAM index reference for read ordering
- rd_mask  out  COL  valid-tap mask
- out_vs  out  1  in_vs aligned to tap data
- out_de  out  1  in_de aligned to tap data
- ovf  out  1  sticky line-overflow flag
- len_err  out  1  sticky line-length mismatch flag

Function
REQ-005 States SHALL be IDLE, LINE, HBLANK and WAIT_VS.
- IDLE is entered from reset; it goes to HBLANK on in_vs.
- HBLANK goes to LINE on in_de=1.
- LINE goes to HBLANK on in_de=0.
- in_vs in any state SHALL force HBLANK and perform the frame restart of REQ-010.
- in_de while in IDLE SHALL be ignored.
REQ-006 All RAM-side outputs (wr_en/wr_addr/wr_data/rd_en/rd_addr) SHALL be registered, 1 cycle after the corresponding in_de/in_data.
REQ-007 Write and read addresses:
- wr_en = rd_en = registered in_de, qualified by state LINE and not address-saturated.
- rd_addr = wr_addr.
- wr_addr starts at 0 on each line and increments by 1 per accepted pixel.
REQ-008 When wr_addr = 2^ASIZE-1 and a further in_de pixel arrives:
- that pixel SHALL be dropped (wr_en=0);
- ovf SHALL set;
- dropping continues until the end of the line.
REQ-009 On the first cycle of HBLANK after LINE:
- wr_point SHALL advance by 1 modulo COL;
- lines_done (internal, saturating at COL) SHALL increment.
REQ-010 Frame restart: in_vs SHALL set wr_point=0, lines_done=0 and wr_addr=0 on the next cycle; a line in progress is aborted without a point advance.
REQ-011 rd_point SHALL equal wr_point every cycle.
REQ-012 rd_mask[k] SHALL be 1 iff k < lines_done, registered and updated together with wr_point.
REQ-013 wr_point and rd_mask SHALL change only while wr_en=0, because the downstream RAM pointers latch during write-idle cycles. A horizontal blank of at least 2 cycles is required.
REQ-014 A blank of 1 cycle SHALL still advance the pointer; tap ordering for the following line is then undefined, and no flag is raised.
REQ-015 out_de and out_vs SHALL be in_de and in_vs delayed exactly 3 cycles: 1 controller cycle, 1 RAM read cycle and 1 output-ordering cycle.
REQ-016 in_vs and in_de asserted in the same cycle: the restart takes effect first, and the pixel is written at address 0 into RAM 0.

Reset
REQ-017 While rst=1, all of the following SHALL be 0:
- outputs: wr_en, wr_addr, wr_data, rd_en, rd_addr, wr_point, rd_point, rd_mask, out_vs, out_de, ovf, len_err;
- internal state: the delay pipeline and lines_done.
REQ-018 State SHALL be IDLE during reset, and reset assertion mid-line SHALL abort immediately.
REQ-019 ovf and len_err SHALL clear only on rst or in_vs.

Configuration
REQ-020 Macro VIDEO_SHIFT_CTRL_LEN_CHECK_EN, when defined:
- the pixel count of the first line after in_vs is captured as the reference;
- any later line of the same frame with a different count SHALL set len_err.
REQ-021 Without VIDEO_SHIFT_CTRL_LEN_CHECK_EN:
- len_err SHALL be tied to 0;
- no capture logic is built;
- all other behaviour is identical.

Verification
REQ-022 Directed scenarios the bench SHALL cover:
- Reset check: rst=1 mid-line -> all outputs 0 next cycle, state IDLE; in_de with no in_vs -> wr_en stays 0.
- COL=3: in_vs, then 4 lines of 8 pixels with 4-cycle blanks -> wr_point sequence 0,1,2,0; rd_mask 000, 001, 011, 111, 111; wr_addr 0..7 on each line.
- ASIZE=3: a line of 10 pixels -> 8 writes (addresses 0..7), pixels 9-10 dropped, ovf=1 until the next in_vs.
- in_vs at pixel 5 of line 2 -> wr_point=0, rd_mask=0, and the next line writes from address 0.
- out_de alignment: out_de rises exactly 3 cycles after in_de and has the same width.
- With VIDEO_SHIFT_CTRL_LEN_CHECK_EN, lines of 16,16,15 pixels -> len_err=1 after the third line. Without the macro, the same stimulus leaves len_err=0.
